etapa_busqueda: RTL and testbench

Instruction-fetch stage of the pipeline: owns the program counter, drives the word address of the instruction memory, and registers the returned 32-bit word into the IF/ID pipeline register. It sits directly upstream of the instruction memory, which has a one-cycle registered read, and directly upstream of decode. It honours stall requests from the hazard detection unit (HDU) and redirects from the branch/jump control unit (SCU). It freezes on a fetched HLT word (32'h00000000).

---
 rtl/etapa_busqueda.sv | 111 +++++++++++
 tb/tb_etapa_busqueda.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/etapa_busqueda.sv
// Instruction-fetch stage: owns the program counter, drives the instruction
// memory word address and registers the returned word into IF/ID. Honours
// stall requests, branch/jump redirects and freezes on a fetched HLT word.
module etapa_busqueda #(
  parameter int          ANCHO_PC  = 10,
  parameter logic [31:0] INSTR_NOP = 32'h00000020,
  parameter logic [31:0] INSTR_HLT = 32'h00000000
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [ANCHO_PC-1:0] direccion,
  input  logic [31:0]         instruccion,
  input  logic                stall,
  input  logic                salto_tomado,
  input  logic [ANCHO_PC-1:0] dir_salto,
  output logic [31:0]         instr_id,
  output logic [ANCHO_PC-1:0] pc_id,
  output logic [ANCHO_PC-1:0] pc_mas1_id,
  output logic                valido_id,
  output logic                detenido
);

  localparam logic [ANCHO_PC-1:0] UNO = {{(ANCHO_PC-1){1'b0}}, 1'b1};

  // Address of the word currently presented on instruccion.
  logic [ANCHO_PC-1:0] pc_q;
  logic [ANCHO_PC-1:0] pc_inc;

  // IF/ID pipeline register and halt flag.
  logic [31:0]         instr_id_q,   instr_id_d;
  logic [ANCHO_PC-1:0] pc_id_q,      pc_id_d;
  logic [ANCHO_PC-1:0] pc_mas1_id_q, pc_mas1_id_d;
  logic                valido_id_q,  valido_id_d;
  logic                detenido_q,   detenido_d;

  logic es_hlt;

  // Sequential successor wraps naturally at 2^ANCHO_PC.
  assign pc_inc = pc_q + UNO;
  assign es_hlt = (instruccion == INSTR_HLT);

  // Next-PC selection; the memory samples this same value on the edge, so
  // pc and instruccion stay aligned.
  always_comb begin
    // NOTE: every branch assigns direccion, and the default below guarantees
    // it, so no latch can be inferred even if a branch is edited later.
    direccion = pc_inc;
    if (!reset_n) begin
      direccion = '0;
    end else if (salto_tomado) begin
      direccion = dir_salto;
    end else if (stall) begin
      direccion = pc_q;
    end else if (detenido_q || es_hlt) begin
      direccion = pc_q;
    end
  end

  // IF/ID next state: redirect flushes, stall holds, halt inserts bubbles.
  always_comb begin
    instr_id_d   = instr_id_q;
    pc_id_d      = pc_id_q;
    pc_mas1_id_d = pc_mas1_id_q;
    valido_id_d  = valido_id_q;
    detenido_d   = detenido_q;
    if (salto_tomado) begin
      // A wrong-path HLT in this cycle is discarded along with the flush.
      instr_id_d  = INSTR_NOP;
      valido_id_d = 1'b0;
      detenido_d  = 1'b0;
    end else if (stall) begin
      // Hold everything; defaults already carry the current values.
    end else if (detenido_q) begin
      instr_id_d  = INSTR_NOP;
      valido_id_d = 1'b0;
    end else begin
      instr_id_d   = instruccion;
      pc_id_d      = pc_q;
      pc_mas1_id_d = pc_inc;
      valido_id_d  = 1'b1;
      detenido_d   = es_hlt;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      pc_q         <= '0;
      instr_id_q   <= INSTR_NOP;
      pc_id_q      <= '0;
      pc_mas1_id_q <= UNO;
      valido_id_q  <= 1'b0;
      detenido_q   <= 1'b0;
    end else begin
      pc_q         <= direccion;
      instr_id_q   <= instr_id_d;
      pc_id_q      <= pc_id_d;
      pc_mas1_id_q <= pc_mas1_id_d;
      valido_id_q  <= valido_id_d;
      detenido_q   <= detenido_d;
    end
  end

  assign instr_id   = instr_id_q;
  assign pc_id      = pc_id_q;
  assign pc_mas1_id = pc_mas1_id_q;
  assign valido_id  = valido_id_q;
  assign detenido   = detenido_q;

endmodule

// File: tb/tb_etapa_busqueda.sv
// Directed bench for etapa_busqueda: a behavioural one-cycle registered ROM
// feeds the stage, and per-cycle vector tables give the expected address
// before each edge and the IF/ID contents after it.
module tb_etapa_busqueda;

  localparam logic [31:0] NOP = 32'h00000020;
  localparam logic [31:0] HLT = 32'h00000000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  direccion;
  logic [31:0] instruccion;
  logic        stall;
  logic        salto_tomado;
  logic [9:0]  dir_salto;
  logic [31:0] instr_id;
  logic [9:0]  pc_id;
  logic [9:0]  pc_mas1_id;
  logic        valido_id;
  logic        detenido;

  logic [31:0] rom [1024];

  int total = 0;
  int bad   = 0;

  etapa_busqueda dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .direccion    (direccion),
    .instruccion  (instruccion),
    .stall        (stall),
    .salto_tomado (salto_tomado),
    .dir_salto    (dir_salto),
    .instr_id     (instr_id),
    .pc_id        (pc_id),
    .pc_mas1_id   (pc_mas1_id),
    .valido_id    (valido_id),
    .detenido     (detenido)
  );

  always #5 clk = ~clk;

  // Instruction memory with one-cycle registered read.
  always @(posedge clk) instruccion <= rom[direccion];

  typedef struct {
    logic        rst_n;
    logic        stl;
    logic        sal;
    logic [9:0]  ds;
    logic [9:0]  e_dir;   // direccion before the edge
    logic [31:0] e_instr; // IF/ID contents after the edge
    logic [9:0]  e_pc;
    logic        chk_pc;  // pc fields are don't-care on bubbles
    logic        e_val;
    logic        e_det;
  } vec_t;

  vec_t tab_a [9];
  vec_t tab_b [32];

  function automatic vec_t mk(input logic r, input logic s, input logic j,
                              input logic [9:0] ds, input logic [9:0] ed,
                              input logic [31:0] ei, input logic [9:0] ep,
                              input logic cp, input logic ev, input logic edt);
    vec_t v;
    v.rst_n = r;  v.stl = s;  v.sal = j;  v.ds = ds;  v.e_dir = ed;
    v.e_instr = ei;  v.e_pc = ep;  v.chk_pc = cp;  v.e_val = ev;  v.e_det = edt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_row(input string tag, input int idx, input vec_t v);
    logic [9:0] e_mas1;
    reset_n      = v.rst_n;
    stall        = v.stl;
    salto_tomado = v.sal;
    dir_salto    = v.ds;
    @(negedge clk);
    check($sformatf("%s[%0d].direccion", tag, idx), 32'(direccion), 32'(v.e_dir));
    @(posedge clk);
    #1;
    check($sformatf("%s[%0d].instr_id", tag, idx), instr_id, v.e_instr);
    check($sformatf("%s[%0d].valido_id", tag, idx), 32'(valido_id), 32'(v.e_val));
    check($sformatf("%s[%0d].detenido", tag, idx), 32'(detenido), 32'(v.e_det));
    if (v.chk_pc) begin
      e_mas1 = v.e_pc + 10'd1;
      check($sformatf("%s[%0d].pc_id", tag, idx), 32'(pc_id), 32'(v.e_pc));
      check($sformatf("%s[%0d].pc_mas1_id", tag, idx), 32'(pc_mas1_id), 32'(e_mas1));
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    stall        = 1'b0;
    salto_tomado = 1'b0;
    dir_salto    = '0;

    // Sequential fetch ending in HLT.
    for (int i = 0; i < 1024; i++) rom[i] = 32'h04000000 | i;
    for (int i = 0; i < 4; i++) rom[i] = 32'h00210820;
    rom[4] = HLT;
    //            rst  stl  sal  ds      dir     instr         pc      cp   val  det
    tab_a[0] = mk(1'b0,1'b0,1'b0,10'd0,  10'd0,  NOP,          10'd0,  1'b1,1'b0,1'b0);
    tab_a[1] = mk(1'b1,1'b0,1'b0,10'd0,  10'd1,  32'h00210820, 10'd0,  1'b1,1'b1,1'b0);
    tab_a[2] = mk(1'b1,1'b0,1'b0,10'd0,  10'd2,  32'h00210820, 10'd1,  1'b1,1'b1,1'b0);
    tab_a[3] = mk(1'b1,1'b0,1'b0,10'd0,  10'd3,  32'h00210820, 10'd2,  1'b1,1'b1,1'b0);
    tab_a[4] = mk(1'b1,1'b0,1'b0,10'd0,  10'd4,  32'h00210820, 10'd3,  1'b1,1'b1,1'b0);
    tab_a[5] = mk(1'b1,1'b0,1'b0,10'd0,  10'd4,  HLT,          10'd4,  1'b1,1'b1,1'b1);
    tab_a[6] = mk(1'b1,1'b0,1'b0,10'd0,  10'd4,  NOP,          10'd0,  1'b0,1'b0,1'b1);
    tab_a[7] = mk(1'b1,1'b0,1'b0,10'd0,  10'd4,  NOP,          10'd0,  1'b0,1'b0,1'b1);
    tab_a[8] = mk(1'b1,1'b0,1'b0,10'd0,  10'd4,  NOP,          10'd0,  1'b0,1'b0,1'b1);
    for (int i = 0; i < 9; i++) run_row("seq", i, tab_a[i]);

    // Jump, stall, redirect priority, wrong-path HLT, wrap-around, mid-run reset.
    for (int i = 0; i < 1024; i++) rom[i] = 32'h04000000 | i;
    rom[0]  = 32'h3C0280FF;
    rom[1]  = 32'h08000000;
    rom[34] = HLT;
    tab_b[0]  = mk(1'b0,1'b0,1'b0,10'd0,   10'd0,   NOP,          10'd0,   1'b1,1'b0,1'b0);
    tab_b[1]  = mk(1'b1,1'b0,1'b0,10'd0,   10'd1,   32'h3C0280FF, 10'd0,   1'b1,1'b1,1'b0);
    tab_b[2]  = mk(1'b1,1'b0,1'b0,10'd0,   10'd2,   32'h08000000, 10'd1,   1'b1,1'b1,1'b0);
    tab_b[3]  = mk(1'b1,1'b0,1'b1,10'd0,   10'd0,   NOP,          10'd0,   1'b0,1'b0,1'b0);
    tab_b[4]  = mk(1'b1,1'b0,1'b0,10'd0,   10'd1,   32'h3C0280FF, 10'd0,   1'b1,1'b1,1'b0);
    tab_b[5]  = mk(1'b1,1'b0,1'b0,10'd0,   10'd2,   32'h08000000, 10'd1,   1'b1,1'b1,1'b0);
    tab_b[6]  = mk(1'b1,1'b1,1'b0,10'd0,   10'd2,   32'h08000000, 10'd1,   1'b1,1'b1,1'b0);
    tab_b[7]  = mk(1'b1,1'b1,1'b0,10'd0,   10'd2,   32'h08000000, 10'd1,   1'b1,1'b1,1'b0);
    tab_b[8]  = mk(1'b1,1'b1,1'b0,10'd0,   10'd2,   32'h08000000, 10'd1,   1'b1,1'b1,1'b0);
    tab_b[9]  = mk(1'b1,1'b0,1'b0,10'd0,   10'd3,   32'h04000002, 10'd2,   1'b1,1'b1,1'b0);
    tab_b[10] = mk(1'b1,1'b0,1'b0,10'd0,   10'd4,   32'h04000003, 10'd3,   1'b1,1'b1,1'b0);
    tab_b[11] = mk(1'b1,1'b1,1'b1,10'd32,  10'd32,  NOP,          10'd0,   1'b0,1'b0,1'b0);
    tab_b[12] = mk(1'b1,1'b0,1'b0,10'd0,   10'd33,  32'h04000020, 10'd32,  1'b1,1'b1,1'b0);
    tab_b[13] = mk(1'b1,1'b0,1'b0,10'd0,   10'd34,  32'h04000021, 10'd33,  1'b1,1'b1,1'b0);
    tab_b[14] = mk(1'b1,1'b0,1'b0,10'd0,   10'd34,  HLT,          10'd34,  1'b1,1'b1,1'b1);
    tab_b[15] = mk(1'b1,1'b0,1'b0,10'd0,   10'd34,  NOP,          10'd0,   1'b0,1'b0,1'b1);
    tab_b[16] = mk(1'b1,1'b0,1'b1,10'd7,   10'd7,   NOP,          10'd0,   1'b0,1'b0,1'b0);
    tab_b[17] = mk(1'b1,1'b0,1'b0,10'd0,   10'd8,   32'h04000007, 10'd7,   1'b1,1'b1,1'b0);
    tab_b[18] = mk(1'b1,1'b0,1'b1,10'd33,  10'd33,  NOP,          10'd0,   1'b0,1'b0,1'b0);
    tab_b[19] = mk(1'b1,1'b0,1'b0,10'd0,   10'd34,  32'h04000021, 10'd33,  1'b1,1'b1,1'b0);
    tab_b[20] = mk(1'b1,1'b0,1'b1,10'd1022,10'd1022,NOP,          10'd0,   1'b0,1'b0,1'b0);
    tab_b[21] = mk(1'b1,1'b0,1'b0,10'd0,   10'd1023,32'h040003FE, 10'd1022,1'b1,1'b1,1'b0);
    tab_b[22] = mk(1'b1,1'b0,1'b0,10'd0,   10'd0,   32'h040003FF, 10'd1023,1'b1,1'b1,1'b0);
    tab_b[23] = mk(1'b1,1'b0,1'b0,10'd0,   10'd1,   32'h3C0280FF, 10'd0,   1'b1,1'b1,1'b0);
    tab_b[24] = mk(1'b1,1'b0,1'b0,10'd0,   10'd2,   32'h08000000, 10'd1,   1'b1,1'b1,1'b0);
    tab_b[25] = mk(1'b1,1'b0,1'b0,10'd0,   10'd3,   32'h04000002, 10'd2,   1'b1,1'b1,1'b0);
    tab_b[26] = mk(1'b1,1'b0,1'b0,10'd0,   10'd4,   32'h04000003, 10'd3,   1'b1,1'b1,1'b0);
    tab_b[27] = mk(1'b1,1'b0,1'b0,10'd0,   10'd5,   32'h04000004, 10'd4,   1'b1,1'b1,1'b0);
    tab_b[28] = mk(1'b1,1'b0,1'b0,10'd0,   10'd6,   32'h04000005, 10'd5,   1'b1,1'b1,1'b0);
    tab_b[29] = mk(1'b1,1'b1,1'b0,10'd0,   10'd6,   32'h04000005, 10'd5,   1'b1,1'b1,1'b0);
    tab_b[30] = mk(1'b0,1'b1,1'b0,10'd0,   10'd0,   NOP,          10'd0,   1'b1,1'b0,1'b0);
    tab_b[31] = mk(1'b1,1'b0,1'b0,10'd0,   10'd1,   32'h3C0280FF, 10'd0,   1'b1,1'b1,1'b0);
    for (int i = 0; i < 32; i++) begin
      run_row("mix", i, tab_b[i]);
      // Right after the mid-run reset the memory must be presenting rom[0].
      if (i == 30) check("mix.post_reset_instruccion", instruccion, 32'h3C0280FF);
    end

    // Halt with stall held: detenido stays, no reissue, address frozen.
    stall = 1'b0;
    salto_tomado = 1'b1;
    dir_salto = 10'd33;
    @(posedge clk); #1;
    salto_tomado = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("halt2.instr_id", instr_id, HLT);
    check("halt2.detenido", 32'(detenido), 32'd1);
    stall = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("halt2.stall_hold_valido", 32'(valido_id), 32'd1);
    check("halt2.stall_hold_det", 32'(detenido), 32'd1);
    stall = 1'b0;
    @(posedge clk); #1;
    check("halt2.bubble_valido", 32'(valido_id), 32'd0);
    check("halt2.direccion", 32'(direccion), 32'd34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
